// File: rtl/key_evt_pkg.sv
// Shared event-type and key-FSM encodings for the key event scheduler.
package key_evt_pkg;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'b00,
        EVT_SHORT  = 2'b01,
        EVT_LONG   = 2'b10,
        EVT_REPEAT = 2'b11
    } evt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRESS = 2'b01,
        ST_HOLD  = 2'b10
    } key_state_t;

    function automatic int unsigned kidx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_press_fsm.sv
// Per-key press classifier with a 1-deep pending event slot and sticky overflow flag.
// KEY_EVT_REPEAT_EN enables periodic REPEAT events while the key stays held.
module key_press_fsm
    import key_evt_pkg::*;
#(
    parameter int unsigned LONG_MS = 1000,
`ifdef KEY_EVT_REPEAT_EN
    parameter int unsigned REP_MS  = 200,
`endif
    parameter int unsigned MS_W    = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       key_lvl_n,
    input  logic       grant,
    input  logic       ovf_clr,
    output logic       pend_valid,
    output logic [1:0] pend_type,
    output logic       ovf
);

    localparam logic [MS_W-1:0] LONG_TH = MS_W'(LONG_MS);
`ifdef KEY_EVT_REPEAT_EN
    localparam logic [MS_W-1:0] REP_TH  = MS_W'(REP_MS);
`endif

    key_state_t      state_q, state_d;
    logic [MS_W-1:0] hms_q, hms_d;
    logic [MS_W-1:0] hms_inc;
    logic            pend_valid_q, pend_valid_d;
    logic [1:0]      pend_type_q, pend_type_d;
    logic            ovf_q, ovf_d;
    logic            fire;
    evt_type_t       fire_type;

    always_comb begin
        state_d   = state_q;
        hms_d     = hms_q;
        fire      = 1'b0;
        fire_type = EVT_NONE;
        hms_inc   = (&hms_q) ? hms_q : hms_q + MS_W'(1);

        // Release is checked before the threshold so it wins a same-cycle tie.
        unique case (state_q)
            ST_IDLE: begin
                if (!key_lvl_n) begin
                    state_d = ST_PRESS;
                    hms_d   = '0;
                end
            end
            ST_PRESS: begin
                if (key_lvl_n) begin
                    state_d = ST_IDLE;
                    if (hms_q < LONG_TH) begin
                        fire      = 1'b1;
                        fire_type = EVT_SHORT;
                    end
                end else if (hms_q >= LONG_TH) begin
                    fire      = 1'b1;
                    fire_type = EVT_LONG;
                    state_d   = ST_HOLD;
                    hms_d     = '0;
                end else if (tick) begin
                    hms_d = hms_inc;
                end
            end
            ST_HOLD: begin
                if (key_lvl_n) begin
                    state_d = ST_IDLE;
                end
`ifdef KEY_EVT_REPEAT_EN
                else if (hms_q >= REP_TH) begin
                    fire      = 1'b1;
                    fire_type = EVT_REPEAT;
                    hms_d     = '0;
                end else if (tick) begin
                    hms_d = hms_inc;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A grant in the same cycle frees the slot, so the new event is stored.
    always_comb begin
        pend_valid_d = pend_valid_q & ~grant;
        pend_type_d  = pend_type_q;
        ovf_d        = ovf_q & ~ovf_clr;
        if (fire) begin
            if (pend_valid_q && !grant) begin
                ovf_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_type_d  = fire_type;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hms_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_type_q  <= EVT_NONE;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hms_q        <= hms_d;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
            ovf_q        <= ovf_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_type  = pend_type_q;
    assign ovf        = ovf_q;

endmodule

// File: rtl/key_evt_sched.sv
// Key event scheduler top: 1 ms prescaler, per-key classifiers, round-robin arbiter, output register.
// KEY_EVT_REPEAT_EN enables REPEAT events in the per-key classifiers.
module key_evt_sched
    import key_evt_pkg::*;
#(
    parameter  int unsigned KEY_WIDTH = 3,
    parameter  int unsigned TICK_DIV  = 12000,
    parameter  int unsigned LONG_MS   = 1000,
    parameter  int unsigned REP_MS    = 200,
    parameter  int unsigned MS_W      = 11,
    localparam int unsigned KIDX_W    = kidx_w(KEY_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_WIDTH-1:0] key_lvl_n,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [KIDX_W-1:0]    evt_key,
    output logic [1:0]           evt_type,
    output logic [KEY_WIDTH-1:0] evt_ovf,
    input  logic                 ovf_clr
);

    localparam int unsigned     PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam int unsigned     MAX_MS  = (LONG_MS > REP_MS) ? LONG_MS : REP_MS;

    if ((64'd1 << MS_W) <= 64'(MAX_MS)) begin : g_ms_w_check
        $error("MS_W too narrow for LONG_MS/REP_MS");
    end

    logic [PS_W-1:0]             ps_q, ps_d;
    logic                        tick;
    logic [KEY_WIDTH-1:0]        pend_valid;
    logic [KEY_WIDTH-1:0][1:0]   pend_type;
    logic [KEY_WIDTH-1:0]        grant;
    logic                        found;
    logic [KIDX_W-1:0]           gidx;
    logic [KIDX_W-1:0]           last_grant_q, last_grant_d;
    logic                        evt_valid_q, evt_valid_d;
    logic [KIDX_W-1:0]           evt_key_q, evt_key_d;
    logic [1:0]                  evt_type_q, evt_type_d;

    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = tick ? '0 : ps_q + PS_W'(1);
    end

    for (genvar k = 0; k < KEY_WIDTH; k++) begin : g_key
        key_press_fsm #(
            .LONG_MS (LONG_MS),
`ifdef KEY_EVT_REPEAT_EN
            .REP_MS  (REP_MS),
`endif
            .MS_W    (MS_W)
        ) u_fsm (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .key_lvl_n  (key_lvl_n[k]),
            .grant      (grant[k]),
            .ovf_clr    (ovf_clr),
            .pend_valid (pend_valid[k]),
            .pend_type  (pend_type[k]),
            .ovf        (evt_ovf[k])
        );
    end

    // Search starts one past the last grant; the output register must be free or draining.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        gidx  = '0;
        grant = '0;
        if (!evt_valid_q || evt_ready) begin
            for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
                idx = (int'(last_grant_q) + 1 + i) % KEY_WIDTH;
                if (!found && pend_valid[idx]) begin
                    found = 1'b1;
                    gidx  = KIDX_W'(idx);
                end
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_key_d    = evt_key_q;
        evt_type_d   = evt_type_q;
        last_grant_d = last_grant_q;
        if (found) begin
            evt_valid_d  = 1'b1;
            evt_key_d    = gidx;
            evt_type_d   = pend_type[gidx];
            last_grant_d = gidx;
        end else if (evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q         <= '0;
            last_grant_q <= '0;
            evt_valid_q  <= 1'b0;
            evt_key_q    <= '0;
            evt_type_q   <= EVT_NONE;
        end else begin
            ps_q         <= ps_d;
            last_grant_q <= last_grant_d;
            evt_valid_q  <= evt_valid_d;
            evt_key_q    <= evt_key_d;
            evt_type_q   <= evt_type_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_key   = evt_key_q;
    assign evt_type  = evt_type_q;

endmodule

// File: tb/tb_key_evt_sched.sv
// Scoreboard bench for key_evt_sched (TICK_DIV=4, LONG_MS=10, REP_MS=3, KEY_WIDTH=3).
module tb_key_evt_sched;
    import key_evt_pkg::*;

    localparam int unsigned KW = 3;
    localparam int unsigned TD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] key_lvl_n = '1;
    logic          evt_ready = 1'b1;
    logic          ovf_clr = 1'b0;
    logic          evt_valid;
    logic [1:0]    evt_key;
    logic [1:0]    evt_type;
    logic [KW-1:0] evt_ovf;

    key_evt_sched #(
        .KEY_WIDTH (KW),
        .TICK_DIV  (TD),
        .LONG_MS   (10),
        .REP_MS    (3),
        .MS_W      (11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_lvl_n (key_lvl_n),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_type  (evt_type),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the prescaler ticks on every edge that is a multiple of TD.
    int unsigned pcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcnt <= 0;
        else        pcnt <= pcnt + 1;
    end

    typedef struct packed {
        logic [1:0] key;
        logic [1:0] typ;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_evt", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("evt_key", int'(evt_key), int'(mon_e.key));
                chk("evt_type", int'(evt_type), int'(mon_e.typ));
            end
        end
    end

    task automatic cyc(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [1:0] t);
        sb.push_back({k, t});
    endtask

    task automatic press_cycles(input logic [KW-1:0] mask, input int unsigned n);
        key_lvl_n = key_lvl_n & ~mask;
        cyc(n);
        key_lvl_n = key_lvl_n | mask;
    endtask

    // Release right after the edge that performs the n-th hold-counter increment.
    task automatic press_incs(input int unsigned k, input int unsigned n);
        int unsigned c0;
        int unsigned incs;
        int unsigned guard;
        c0 = pcnt;
        incs = 0;
        guard = 0;
        key_lvl_n[k] = 1'b0;
        while (incs < n && guard < n * TD + 16) begin
            cyc(1);
            guard++;
            if (pcnt >= c0 + 2 && (pcnt % TD) == 0) incs++;
        end
        key_lvl_n[k] = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int unsigned budget, output int unsigned n);
        n = 0;
        while (!evt_valid && n < budget) begin
            cyc(1);
            n++;
        end
        chk(tag, evt_valid, 1);
    endtask

    task automatic drain(input string tag);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            cyc(1);
            n++;
        end
        cyc(6);
        chk(tag, sb.size(), 0);
    endtask

    task automatic contention(input string tag);
        int unsigned n;
        press_cycles(3'b111, 2 * TD);
        wait_valid({tag, "_valid"}, 20, n);
        cyc(1);
        chk({tag, "_b2b1"}, evt_valid, 1);
        cyc(1);
        chk({tag, "_b2b2"}, evt_valid, 1);
        drain({tag, "_drain"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d checks", checks);
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned seen;

        cyc(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_key", evt_key, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_ovf", evt_ovf, 0);
        rst_n = 1'b1;
        cyc(2);

        // Short press and its two-cycle latency.
        push(2'd0, EVT_SHORT);
        press_cycles(3'b001, 5 * TD);
        n = 0;
        while (!evt_valid && n < 20) begin
            cyc(1);
            n++;
        end
        chk("t1_latency", n, 2);
        drain("t1_drain");

        // Long hold on key1.
        push(2'd1, EVT_LONG);
`ifdef KEY_EVT_REPEAT_EN
        push(2'd1, EVT_REPEAT);
        push(2'd1, EVT_REPEAT);
        push(2'd1, EVT_REPEAT);
`endif
        press_cycles(3'b010, 20 * TD);
        drain("t2_drain");

        // Contention: last grant 2 -> order 0,1,2; last grant 1 -> order 2,0,1.
        push(2'd2, EVT_SHORT);
        press_cycles(3'b100, 2 * TD);
        drain("t3_pre2");
        push(2'd0, EVT_SHORT);
        push(2'd1, EVT_SHORT);
        push(2'd2, EVT_SHORT);
        contention("t3a");
        push(2'd1, EVT_SHORT);
        press_cycles(3'b010, 2 * TD);
        drain("t3_pre1");
        push(2'd2, EVT_SHORT);
        push(2'd0, EVT_SHORT);
        push(2'd1, EVT_SHORT);
        contention("t3b");

        // Backpressure: output register and pending slot fill, third press is dropped.
        evt_ready = 1'b0;
        push(2'd0, EVT_SHORT);
        push(2'd0, EVT_SHORT);
        for (int i = 0; i < 3; i++) begin
            press_cycles(3'b001, 2 * TD);
            cyc(3);
            chk("t4_hold_valid", evt_valid, 1);
            chk("t4_hold_key", evt_key, 0);
            chk("t4_hold_type", evt_type, EVT_SHORT);
        end
        chk("t4_ovf", evt_ovf, 3'b001);
        evt_ready = 1'b1;
        drain("t4_drain");
        chk("t4_ovf_sticky", evt_ovf, 3'b001);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", evt_ovf, 0);

        // Boundary: release with hms at the threshold -> nothing; one below -> SHORT.
        press_incs(0, 10);
        seen = 0;
        repeat (12) begin
            cyc(1);
            if (evt_valid) seen++;
        end
        chk("t5_quiet", seen, 0);
        push(2'd0, EVT_SHORT);
        press_incs(0, 9);
        drain("t5_short9");
        push(2'd0, EVT_SHORT);
        press_cycles(3'b001, 2 * TD);
        drain("t5_idle_again");

        // Reset mid-hold with a stalled event and an overflow bit outstanding.
        evt_ready = 1'b0;
        push(2'd2, EVT_SHORT);
        push(2'd2, EVT_SHORT);
        for (int i = 0; i < 3; i++) begin
            press_cycles(3'b100, 2 * TD);
            cyc(3);
        end
        chk("t6_pre_ovf", evt_ovf, 3'b100);
        chk("t6_pre_key", evt_key, 2);
        key_lvl_n[0] = 1'b0;
        cyc(7 * TD);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", evt_valid, 0);
        chk("t6_rst_key", evt_key, 0);
        chk("t6_rst_type", evt_type, 0);
        chk("t6_rst_ovf", evt_ovf, 0);
        sb.delete();
        evt_ready = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        push(2'd0, EVT_LONG);
        wait_valid("t6_long_valid", 80, n);
        chk("t6_long_edge", pcnt, 10 * TD + 2);
        key_lvl_n[0] = 1'b1;
        drain("t6_drain");

        chk("final_sb", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
